pci_mstr_pad_mux: RTL and testbench

Output-side stage between the PCI write-only master and the PCI pads. It merges the master's AD/C-BE/FRAME#/IRDY# drive with the local target's AD read drive. A one-cycle AD register aligns address and data with the master's registered FRAME#. An ownership state machine guarantees a turnaround cycle between drivers, and PAR/PAR-enable are generated one clock after each driven AD phase.

---
 rtl/hbi_pci_pkg.sv | 24 ++
 rtl/pci_par_gen.sv | 34 +++
 rtl/pci_mstr_pad_mux.sv | 147 ++++++++++++++
 tb/tb_pci_mstr_pad_mux.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hbi_pci_pkg.sv
// ============================================================================
// Module   : hbi_pci_pkg
// Purpose  : Shared PCI widths and AD-bus ownership state encoding for the
//            host-bus PCI interface blocks.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package hbi_pci_pkg;

    localparam int AD_W  = 32;
    localparam int CBE_W = 4;

    // Who currently owns the shared AD pads
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MSTR = 2'd1,
        TGT  = 2'd2,
        TURN = 2'd3
    } own_state_t;

endpackage

`default_nettype wire

// File: rtl/pci_par_gen.sv
// ============================================================================
// Module   : pci_par_gen
// Purpose  : PCI parity generator. Registers the XOR of a 36-bit AD+C/BE
//            phase together with a one-cycle delayed enable, so PAR lands on
//            the cycle after the AD phase it covers.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pci_par_gen
    import hbi_pci_pkg::*;
(
    input  logic                    hb_clk,
    input  logic                    reset_n,
    input  logic [AD_W+CBE_W-1:0]   data,
    input  logic                    data_vld,
    output logic                    par_out,
    output logic                    par_oe
);

    // Parity and its enable trail the covered AD phase by one clock
    always_ff @(posedge hb_clk or negedge reset_n) begin
        if (!reset_n) begin
            par_out <= 1'b0;
            par_oe  <= 1'b0;
        end else begin
            par_out <= ^data;
            par_oe  <= data_vld;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pci_mstr_pad_mux.sv
// ============================================================================
// Module   : pci_mstr_pad_mux
// Purpose  : Output stage between the PCI write-only master and the pads.
//            Arbitrates AD ownership between master and local target with a
//            mandatory turnaround cycle, registers AD, and generates PAR.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pci_mstr_pad_mux
    import hbi_pci_pkg::*;
(
    input  logic                hb_clk,
    input  logic                reset_n,
    input  logic [AD_W-1:0]     wom_ad_out,
    input  logic                wom_ad_oe,
    input  logic [CBE_W-1:0]    wom_c_be_out,
    input  logic                wom_frame_out_n,
    input  logic                wom_frame_oe_n,
    input  logic                wom_irdy_n,
    input  logic                wom_irdy_oe_n,
    input  logic [AD_W-1:0]     tgt_ad_out,
    input  logic                tgt_ad_oe,
    input  logic [CBE_W-1:0]    pci_cbe_in,
    input  logic                err_clr,
    output logic [AD_W-1:0]     pci_ad_out,
    output logic                pci_ad_oe,
    output logic [CBE_W-1:0]    pci_cbe_out,
    output logic                pci_cbe_oe,
    output logic                pci_frame_n,
    output logic                pci_frame_oe,
    output logic                pci_irdy_n,
    output logic                pci_irdy_oe,
    output logic                pci_par_out,
    output logic                pci_par_oe,
    output logic                mstr_owns,
    output logic                conflict_err,
    output logic                turn_err
);

    own_state_t         r_state;
    own_state_t         w_next;
    logic               w_grant_m;
    logic               w_grant_t;
    logic               w_conflict_set;
    logic               w_turn_set;
    logic [CBE_W-1:0]   w_cbe_p;

    // Ownership state register
    always_ff @(posedge hb_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next owner and error-set conditions; TURN never grants, even a request
    // that arrives during it is only considered once back in IDLE
    always_comb begin
        w_next         = r_state;
        w_conflict_set = 1'b0;
        w_turn_set     = 1'b0;
        case (r_state)
            IDLE: begin
                if (wom_ad_oe) begin
                    w_next         = MSTR;
                    w_conflict_set = tgt_ad_oe;
                end else if (tgt_ad_oe) begin
                    w_next = TGT;
                end
            end
            MSTR: begin
                w_conflict_set = tgt_ad_oe;
                if (!wom_ad_oe) begin
                    w_next = TURN;
                end
            end
            TGT: begin
                w_conflict_set = wom_ad_oe;
                if (!tgt_ad_oe) begin
                    w_next = TURN;
                end
            end
            TURN: begin
                w_turn_set = wom_ad_oe | tgt_ad_oe;
                w_next     = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_grant_m = (w_next == MSTR) && wom_ad_oe;
    assign w_grant_t = (w_next == TGT)  && tgt_ad_oe;

    // AD pad register: aligns the master's combinational AD with its
    // registered FRAME#/C-BE#
    always_ff @(posedge hb_clk or negedge reset_n) begin
        if (!reset_n) begin
            pci_ad_out <= '0;
            pci_ad_oe  <= 1'b0;
            pci_cbe_oe <= 1'b0;
        end else begin
            pci_ad_out <= w_grant_t ? tgt_ad_out : wom_ad_out;
            pci_ad_oe  <= w_grant_m | w_grant_t;
            pci_cbe_oe <= w_grant_m;
        end
    end

    // Sticky error flags; a clear wins over a same-cycle set
    always_ff @(posedge hb_clk or negedge reset_n) begin
        if (!reset_n) begin
            conflict_err <= 1'b0;
            turn_err     <= 1'b0;
        end else if (err_clr) begin
            conflict_err <= 1'b0;
            turn_err     <= 1'b0;
        end else begin
            conflict_err <= conflict_err | w_conflict_set;
            turn_err     <= turn_err | w_turn_set;
        end
    end

    assign mstr_owns    = (r_state == MSTR);
    assign pci_cbe_out  = wom_c_be_out;
    assign pci_frame_n  = wom_frame_out_n;
    assign pci_frame_oe = ~wom_frame_oe_n;
    assign pci_irdy_n   = wom_irdy_n;
    assign pci_irdy_oe  = ~wom_irdy_oe_n;

    // Parity covers our own C/BE# when the master drives, the bus C/BE# otherwise
    assign w_cbe_p = mstr_owns ? pci_cbe_out : pci_cbe_in;

    pci_par_gen u_par_gen (
        .hb_clk   (hb_clk),
        .reset_n  (reset_n),
        .data     ({pci_ad_out, w_cbe_p}),
        .data_vld (pci_ad_oe),
        .par_out  (pci_par_out),
        .par_oe   (pci_par_oe)
    );

endmodule

`default_nettype wire

// File: tb/tb_pci_mstr_pad_mux.sv
// ============================================================================
// Module   : tb_pci_mstr_pad_mux
// Purpose  : Self-checking bench for pci_mstr_pad_mux: directed scenarios
//            followed by randomized requests against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pci_mstr_pad_mux;

    logic        hb_clk;
    logic        reset_n;
    logic [31:0] wom_ad_out;
    logic        wom_ad_oe;
    logic [3:0]  wom_c_be_out;
    logic        wom_frame_out_n;
    logic        wom_frame_oe_n;
    logic        wom_irdy_n;
    logic        wom_irdy_oe_n;
    logic [31:0] tgt_ad_out;
    logic        tgt_ad_oe;
    logic [3:0]  pci_cbe_in;
    logic        err_clr;
    logic [31:0] pci_ad_out;
    logic        pci_ad_oe;
    logic [3:0]  pci_cbe_out;
    logic        pci_cbe_oe;
    logic        pci_frame_n;
    logic        pci_frame_oe;
    logic        pci_irdy_n;
    logic        pci_irdy_oe;
    logic        pci_par_out;
    logic        pci_par_oe;
    logic        mstr_owns;
    logic        conflict_err;
    logic        turn_err;

    int tests;
    int fails;

    // Reference model: owner is 0 = nobody, 1 = master, 2 = target;
    // gap marks the enforced dead cycle after any owner lets go.
    int          m_owner;
    bit          m_gap;
    logic [31:0] e_ad_out;
    logic        e_ad_oe;
    logic        e_cbe_oe;
    logic        e_par_out;
    logic        e_par_oe;
    logic        e_conf;
    logic        e_turn;

    pci_mstr_pad_mux dut (
        .hb_clk          (hb_clk),
        .reset_n         (reset_n),
        .wom_ad_out      (wom_ad_out),
        .wom_ad_oe       (wom_ad_oe),
        .wom_c_be_out    (wom_c_be_out),
        .wom_frame_out_n (wom_frame_out_n),
        .wom_frame_oe_n  (wom_frame_oe_n),
        .wom_irdy_n      (wom_irdy_n),
        .wom_irdy_oe_n   (wom_irdy_oe_n),
        .tgt_ad_out      (tgt_ad_out),
        .tgt_ad_oe       (tgt_ad_oe),
        .pci_cbe_in      (pci_cbe_in),
        .err_clr         (err_clr),
        .pci_ad_out      (pci_ad_out),
        .pci_ad_oe       (pci_ad_oe),
        .pci_cbe_out     (pci_cbe_out),
        .pci_cbe_oe      (pci_cbe_oe),
        .pci_frame_n     (pci_frame_n),
        .pci_frame_oe    (pci_frame_oe),
        .pci_irdy_n      (pci_irdy_n),
        .pci_irdy_oe     (pci_irdy_oe),
        .pci_par_out     (pci_par_out),
        .pci_par_oe      (pci_par_oe),
        .mstr_owns       (mstr_owns),
        .conflict_err    (conflict_err),
        .turn_err        (turn_err)
    );

    initial hb_clk = 1'b0;
    always #5 hb_clk = ~hb_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = 0;
        m_gap     = 1'b0;
        e_ad_out  = '0;
        e_ad_oe   = 1'b0;
        e_cbe_oe  = 1'b0;
        e_par_out = 1'b0;
        e_par_oe  = 1'b0;
        e_conf    = 1'b0;
        e_turn    = 1'b0;
    endtask

    task automatic check_all();
        chk("ad_out",    pci_ad_out,            e_ad_out);
        chk("ad_oe",     32'(pci_ad_oe),        32'(e_ad_oe));
        chk("cbe_out",   32'(pci_cbe_out),      32'(wom_c_be_out));
        chk("cbe_oe",    32'(pci_cbe_oe),       32'(e_cbe_oe));
        chk("frame_n",   32'(pci_frame_n),      32'(wom_frame_out_n));
        chk("frame_oe",  32'(pci_frame_oe),     32'(!wom_frame_oe_n));
        chk("irdy_n",    32'(pci_irdy_n),       32'(wom_irdy_n));
        chk("irdy_oe",   32'(pci_irdy_oe),      32'(!wom_irdy_oe_n));
        chk("par_out",   32'(pci_par_out),      32'(e_par_out));
        chk("par_oe",    32'(pci_par_oe),       32'(e_par_oe));
        chk("mstr_owns", 32'(mstr_owns),        32'(m_owner == 1));
        chk("conflict",  32'(conflict_err),     32'(e_conf));
        chk("turn_err",  32'(turn_err),         32'(e_turn));
    endtask

    // Advance the model by one clock using the inputs currently applied,
    // then let the DUT take the same edge and compare everything.
    task automatic tick();
        int   nxt;
        bit   nxt_gap;
        bit   cset;
        bit   tset;
        logic [3:0] cbe_used;
        nxt     = m_owner;
        nxt_gap = 1'b0;
        cset    = 1'b0;
        tset    = 1'b0;
        cbe_used = (m_owner == 1) ? wom_c_be_out : pci_cbe_in;
        e_par_out = ^{e_ad_out, cbe_used};
        e_par_oe  = e_ad_oe;
        if (m_gap) begin
            tset = wom_ad_oe | tgt_ad_oe;
            nxt  = 0;
        end else if (m_owner == 0) begin
            if (wom_ad_oe) begin
                nxt  = 1;
                cset = tgt_ad_oe;
            end else if (tgt_ad_oe) begin
                nxt = 2;
            end
        end else if (m_owner == 1) begin
            cset = tgt_ad_oe;
            if (!wom_ad_oe) begin
                nxt     = 0;
                nxt_gap = 1'b1;
            end
        end else begin
            cset = wom_ad_oe;
            if (!tgt_ad_oe) begin
                nxt     = 0;
                nxt_gap = 1'b1;
            end
        end
        e_ad_out = (nxt == 2) ? tgt_ad_out : wom_ad_out;
        e_ad_oe  = (nxt != 0);
        e_cbe_oe = (nxt == 1);
        if (err_clr) begin
            e_conf = 1'b0;
            e_turn = 1'b0;
        end else begin
            e_conf = e_conf | cset;
            e_turn = e_turn | tset;
        end
        m_owner = nxt;
        m_gap   = nxt_gap;
        @(posedge hb_clk);
        #1;
        check_all();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset_n         = 1'b0;
        wom_ad_out      = '0;
        wom_ad_oe       = 1'b0;
        wom_c_be_out    = 4'hF;
        wom_frame_out_n = 1'b1;
        wom_frame_oe_n  = 1'b1;
        wom_irdy_n      = 1'b1;
        wom_irdy_oe_n   = 1'b1;
        tgt_ad_out      = '0;
        tgt_ad_oe       = 1'b0;
        pci_cbe_in      = 4'hF;
        err_clr         = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge hb_clk);
        #1;
        chk("rst_ad_out", pci_ad_out, 32'h0);
        chk("rst_ad_oe", 32'(pci_ad_oe), 32'h0);
        chk("rst_frame_n", 32'(pci_frame_n), 32'h1);
        check_all();
        @(negedge hb_clk);
        reset_n = 1'b1;

        // Master write: address then one data phase
        wom_ad_oe = 1'b1; wom_ad_out = 32'h1234_5678;
        tick();
        chk("addr_ad_oe", 32'(pci_ad_oe), 32'h1);
        chk("addr_ad", pci_ad_out, 32'h1234_5678);
        wom_ad_out = 32'h8000_0041; wom_c_be_out = 4'h7;
        wom_frame_out_n = 1'b0; wom_frame_oe_n = 1'b0;
        tick();
        chk("data_ad", pci_ad_out, 32'h8000_0041);
        wom_ad_oe = 1'b0; wom_c_be_out = 4'h0;
        wom_frame_out_n = 1'b1; wom_irdy_n = 1'b0; wom_irdy_oe_n = 1'b0;
        tick();
        chk("rel_ad_oe", 32'(pci_ad_oe), 32'h0);
        chk("rel_par_oe", 32'(pci_par_oe), 32'h1);

        // Target request lands in the turnaround cycle
        wom_frame_oe_n = 1'b1; wom_irdy_n = 1'b1; wom_irdy_oe_n = 1'b1;
        wom_c_be_out = 4'hF;
        tgt_ad_oe = 1'b1; tgt_ad_out = 32'hDEAD_BEEF;
        tick();
        chk("turn_ad_oe", 32'(pci_ad_oe), 32'h0);
        chk("turn_err_set", 32'(turn_err), 32'h1);
        tick();
        chk("tgt_ad_oe", 32'(pci_ad_oe), 32'h1);
        chk("tgt_data", pci_ad_out, 32'hDEAD_BEEF);
        err_clr = 1'b1;
        tick();
        chk("turn_err_clr", 32'(turn_err), 32'h0);
        err_clr = 1'b0;

        // Target parity over all-ones AD with bus C/BE# = 1
        tgt_ad_out = 32'hFFFF_FFFF; pci_cbe_in = 4'h1;
        tick();
        tgt_ad_oe = 1'b0;
        tick();
        chk("tgt_par", 32'(pci_par_out), 32'h1);
        chk("tgt_cbe_oe", 32'(pci_cbe_oe), 32'h0);
        pci_cbe_in = 4'hF;
        tick();
        tick();

        // Simultaneous requests from IDLE: master wins, conflict flagged
        wom_ad_oe = 1'b1; wom_ad_out = 32'hA5A5_A5A5;
        tgt_ad_oe = 1'b1; tgt_ad_out = 32'h5A5A_5A5A;
        tick();
        chk("conf_ad", pci_ad_out, 32'hA5A5_A5A5);
        chk("conf_err", 32'(conflict_err), 32'h1);
        tgt_ad_oe = 1'b0;
        tick();

        // Asynchronous reset mid-transfer
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_ad_oe", 32'(pci_ad_oe), 32'h0);
        chk("arst_cbe_oe", 32'(pci_cbe_oe), 32'h0);
        chk("arst_par_oe", 32'(pci_par_oe), 32'h0);
        chk("arst_owns", 32'(mstr_owns), 32'h0);
        model_reset();
        wom_ad_oe = 1'b0;
        @(negedge hb_clk);
        reset_n = 1'b1;
        tick();

        // Randomized request traffic
        for (int i = 0; i < 400; i++) begin
            wom_ad_oe       = ($urandom_range(0, 3) != 0) ? wom_ad_oe : ~wom_ad_oe;
            tgt_ad_oe       = ($urandom_range(0, 4) != 0) ? tgt_ad_oe : ~tgt_ad_oe;
            wom_ad_out      = $urandom;
            tgt_ad_out      = $urandom;
            wom_c_be_out    = 4'($urandom);
            pci_cbe_in      = 4'($urandom);
            wom_frame_out_n = 1'($urandom);
            wom_frame_oe_n  = 1'($urandom);
            wom_irdy_n      = 1'($urandom);
            wom_irdy_oe_n   = 1'($urandom);
            err_clr         = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
